// File: rtl/div_issue_ctrl.sv
// Initiator side of the iterative divider handshake for RV64M div/rem.
// Resolves divide-by-zero and signed overflow locally and bypasses the divider.
module div_issue_ctrl #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_op,
  input  logic            in_word,
  input  logic [XLEN-1:0] in_src1,
  input  logic [XLEN-1:0] in_src2,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [XLEN-1:0] res_data,
  output logic            div_valid,
  input  logic            div_ready,
  output logic            div_flush,
  output logic            div_divw,
  output logic            div_signed,
  output logic [XLEN-1:0] div_dividend,
  output logic [XLEN-1:0] div_divisor,
  input  logic            div_out_valid,
  input  logic [XLEN-1:0] div_quotient,
  input  logic [XLEN-1:0] div_remainder
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    DRAIN,
    DONE
  } state_t;

  localparam logic [XLEN-1:0] MIN_NEG =
    {1'b1, {(XLEN-1){1'b0}}};

  state_t state;
  logic   rem_q;
  logic   word_q;

  logic            accept;
  logic            in_signed;
  logic            in_rem;
  logic            div_zero;
  logic            ovf;
  logic            special;
  logic [XLEN-1:0] src1_ext;
  logic [XLEN-1:0] special_res;
  logic [XLEN-1:0] sel;
  logic [XLEN-1:0] cap;

  assign in_ready  = (state == IDLE) && !flush && !rst;
  assign accept    = in_valid && in_ready;
  assign in_signed = ~in_op[0];
  assign in_rem    = in_op[1];

  // W ops judge zero/overflow on the low word only
  assign div_zero = in_word ? (in_src2[31:0] == '0)
                            : (in_src2 == '0);

  assign ovf = in_signed && (in_word
    ? ((in_src1[31:0] == 32'h8000_0000) && (&in_src2[31:0]))
    : ((in_src1 == MIN_NEG) && (&in_src2)));

  assign special = div_zero || ovf;

  assign src1_ext = in_word
    ? {{(XLEN-32){in_src1[31]}}, in_src1[31:0]}
    : in_src1;

  assign special_res = div_zero
    ? (in_rem ? src1_ext : {XLEN{1'b1}})
    : (in_rem ? '0 : src1_ext);

  assign sel = rem_q ? div_remainder : div_quotient;
  assign cap = word_q
    ? {{(XLEN-32){sel[31]}}, sel[31:0]}
    : sel;

  assign div_valid = (state == ISSUE);
  assign res_valid = (state == DONE);

  // WAIT cancels in the flush cycle; an ISSUE handshake lost to flush drains
  assign div_flush = !rst && ((state == DRAIN) ||
                     ((state == WAIT) && flush));

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      rem_q        <= 1'b0;
      word_q       <= 1'b0;
      res_data     <= '0;
      div_divw     <= 1'b0;
      div_signed   <= 1'b0;
      div_dividend <= '0;
      div_divisor  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            rem_q  <= in_rem;
            word_q <= in_word;
            if (special) begin
              res_data <= special_res;
              state    <= DONE;
            end else begin
              div_divw     <= in_word;
              div_signed   <= in_signed;
              div_dividend <= in_src1;
              div_divisor  <= in_src2;
              state        <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (flush) begin
            state <= div_ready ? DRAIN : IDLE;
          end else if (div_ready) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (flush) begin
            state <= IDLE;
          end else if (div_out_valid) begin
            res_data <= cap;
            state    <= DONE;
          end
        end
        DRAIN: begin
          state <= IDLE;
        end
        DONE: begin
          if (flush || res_ready) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Scoreboard bench for div_issue_ctrl with a behavioural divider model.
// Directed cases first, then randomized ops with random stalls and flushes.
`timescale 1ns/1ps
module tb_div_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_op = '0;
  logic        in_word = 1'b0;
  logic [63:0] in_src1 = '0;
  logic [63:0] in_src2 = '0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [63:0] res_data;
  logic        div_valid;
  logic        div_ready;
  logic        div_flush;
  logic        div_divw;
  logic        div_signed;
  logic [63:0] div_dividend;
  logic [63:0] div_divisor;
  logic        div_out_valid;
  logic [63:0] div_quotient;
  logic [63:0] div_remainder;

  div_issue_ctrl #(.XLEN(64)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_op        (in_op),
    .in_word      (in_word),
    .in_src1      (in_src1),
    .in_src2      (in_src2),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_data     (res_data),
    .div_valid    (div_valid),
    .div_ready    (div_ready),
    .div_flush    (div_flush),
    .div_divw     (div_divw),
    .div_signed   (div_signed),
    .div_dividend (div_dividend),
    .div_divisor  (div_divisor),
    .div_out_valid(div_out_valid),
    .div_quotient (div_quotient),
    .div_remainder(div_remainder)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  bit rr_rand = 0;
  bit fl_rand = 0;
  bit stall_rand = 0;
  bit div_hold = 0;
  int force_lat = -1;
  int dv_cycles = 0;

  bit exp_issue = 0;
  bit exp_sg = 0;
  bit exp_w = 0;
  logic [63:0] exp_a = '0;
  logic [63:0] exp_b = '0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  function automatic void arith(input bit sg, input bit w,
                                input logic [63:0] a,
                                input logic [63:0] b,
                                output logic [63:0] q,
                                output logic [63:0] r);
    logic [31:0] x;
    logic [31:0] y;
    x = a[31:0];
    y = b[31:0];
    if (w) begin
      if (y == 0) begin
        q = '1;
        r = {32'b0, x};
      end else if (sg && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
        q = {32'b0, x};
        r = '0;
      end else if (sg) begin
        q = {32'b0, 32'($signed(x) / $signed(y))};
        r = {32'b0, 32'($signed(x) % $signed(y))};
      end else begin
        q = {32'b0, x / y};
        r = {32'b0, x % y};
      end
    end else begin
      if (b == 0) begin
        q = '1;
        r = a;
      end else if (sg && a == 64'h8000_0000_0000_0000 && b == '1) begin
        q = a;
        r = '0;
      end else if (sg) begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end else begin
        q = a / b;
        r = a % b;
      end
    end
  endfunction

  function automatic bit op_signed(input logic [1:0] op);
    return (op == 2'd0) || (op == 2'd2);
  endfunction

  function automatic logic [63:0] ref_result(input logic [1:0] op,
                                             input bit w,
                                             input logic [63:0] a,
                                             input logic [63:0] b);
    logic [63:0] q;
    logic [63:0] r;
    logic [63:0] s;
    arith(op_signed(op), w, a, b, q, r);
    s = (op == 2'd2 || op == 2'd3) ? r : q;
    return w ? {{32{s[31]}}, s[31:0]} : s;
  endfunction

  function automatic bit is_special(input logic [1:0] op, input bit w,
                                    input logic [63:0] a,
                                    input logic [63:0] b);
    bit z;
    bit o;
    z = w ? (b[31:0] == 0) : (b == 0);
    o = op_signed(op) && (w
      ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
      : (a == 64'h8000_0000_0000_0000 && b == '1));
    return z || o;
  endfunction

  // Behavioural multi-cycle divider
  initial begin : divider
    bit busy;
    bit hs;
    bit fl;
    int cnt;
    bit cs;
    bit cw;
    logic [63:0] ca;
    logic [63:0] cb;
    logic [63:0] q;
    logic [63:0] r;
    busy = 0;
    cnt = 0;
    cs = 0;
    cw = 0;
    ca = '0;
    cb = '0;
    div_ready = 1'b1;
    div_out_valid = 1'b0;
    div_quotient = '0;
    div_remainder = '0;
    forever begin
      @(negedge clk);
      hs = !rst && div_valid && div_ready;
      fl = !rst && div_flush;
      if (hs) begin
        chk("issue_expected", 64'(exp_issue), 64'd1);
        chk("issue_ctrl", {62'b0, div_signed, div_divw},
            {62'b0, exp_sg, exp_w});
        chk("issue_dividend", div_dividend, exp_a);
        chk("issue_divisor", div_divisor, exp_b);
        exp_issue = 0;
        cs = div_signed;
        cw = div_divw;
        ca = div_dividend;
        cb = div_divisor;
      end
      if (busy && !fl) begin
        chk("hold_ctrl", {62'b0, div_signed, div_divw}, {62'b0, cs, cw});
        chk("hold_operands", div_dividend ^ div_divisor, ca ^ cb);
      end
      @(posedge clk);
      #1;
      div_out_valid = 1'b0;
      if (rst || fl) begin
        busy = 0;
      end else if (busy) begin
        if (cnt == 0) begin
          arith(div_signed, div_divw, ca, cb, q, r);
          div_quotient = div_divw ? {32'b0, q[31:0]} : q;
          div_remainder = div_divw ? {32'b0, r[31:0]} : r;
          div_out_valid = 1'b1;
          busy = 0;
        end else begin
          cnt--;
        end
      end
      if (hs && !rst && !fl) begin
        busy = 1;
        cnt = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 6));
      end
      div_ready = !busy && !div_hold &&
                  !(stall_rand && $urandom_range(0, 2) == 0);
    end
  end

  // Result monitor
  initial begin : monitor
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (div_valid) dv_cycles++;
        if (div_valid || div_flush)
          chk("flush_with_valid", 64'(div_valid && div_flush), 64'd0);
        if (res_valid && res_ready && !flush) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: got %h expected none",
                     res_data);
          end else begin
            e = exp_q.pop_front();
            chk("result", res_data, e);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rr_rand) res_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input logic [1:0] op, input bit w,
                      input logic [63:0] a, input logic [63:0] b,
                      input logic [63:0] want, output int waited);
    bit acc;
    acc = 0;
    waited = 0;
    in_valid = 1'b1;
    in_op = op;
    in_word = w;
    in_src1 = a;
    in_src2 = b;
    while (!acc && waited < 200) begin
      @(negedge clk);
      if (in_ready) begin
        acc = 1;
        exp_q.push_back(want);
        exp_issue = !is_special(op, w, a, b);
        exp_sg = op_signed(op);
        exp_w = w;
        exp_a = a;
        exp_b = b;
      end
      tick();
      if (!acc) waited++;
    end
    in_valid = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no accept expected accept");
    end
  endtask

  task automatic wait_done(input int limit);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      if (fl_rand && $urandom_range(0, 24) == 0) flush = 1'b1;
      tick();
      if (flush) begin
        flush = 1'b0;
        exp_q.delete();
        exp_issue = 0;
      end
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL result_timeout: got no result expected %h", exp_q[0]);
      exp_q.delete();
    end
  endtask

  initial begin : main
    int waited;
    int dv0;
    int n;
    bit stable;
    bit seen;
    logic [63:0] d;
    logic [1:0] op;
    bit w;
    logic [63:0] a;
    logic [63:0] b;
    int kind;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_flags", {59'b0, res_valid, div_valid, div_flush,
                      div_divw, div_signed}, 64'd0);
    chk("rst_res_data", res_data, 64'd0);
    chk("rst_div_operands", div_dividend | div_divisor, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    force_lat = 3;
    send(2'd1, 0, 64'd100, 64'd7, 64'd14, waited);
    wait_done(100);
    force_lat = -1;
    send(2'd2, 0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, waited);
    wait_done(100);
    send(2'd0, 1, 64'h0000_0000_FFFF_FFF0, 64'd2,
         64'hFFFF_FFFF_FFFF_FFF8, waited);
    wait_done(100);

    dv0 = dv_cycles;
    send(2'd0, 0, 64'd123, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, waited);
    @(negedge clk);
    chk("special_latency", 64'(res_valid), 64'd1);
    wait_done(100);
    send(2'd3, 1, 64'h1_8000_0005, 64'd0, 64'hFFFF_FFFF_8000_0005, waited);
    wait_done(100);
    send(2'd0, 1, 64'h8000_0000, 64'hFFFF_FFFF,
         64'hFFFF_FFFF_8000_0000, waited);
    wait_done(100);
    send(2'd2, 0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
         64'd0, waited);
    wait_done(100);
    chk("bypass_no_div_valid", 64'(dv_cycles), 64'(dv0));

    res_ready = 1'b0;
    send(2'd1, 0, 64'd1000, 64'd10, 64'd100, waited);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!res_valid && n < 100);
    chk("stall_reach_done", 64'(res_valid), 64'd1);
    d = res_data;
    stable = 1;
    repeat (10) begin
      @(negedge clk);
      if (!res_valid || res_data !== d || in_ready) stable = 0;
    end
    chk("stall_stable", 64'(stable), 64'd1);
    @(posedge clk);
    #1;
    res_ready = 1'b1;
    @(negedge clk);
    chk("release_no_bypass", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    send(2'd3, 0, 64'd77, 64'd5, 64'd2, waited);
    chk("next_accept_delay", 64'(waited), 64'd0);
    wait_done(100);

    force_lat = 20;
    send(2'd1, 0, 64'd500, 64'd3, 64'd166, waited);
    repeat (5) @(posedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    chk("wait_flush_pulse", {62'b0, div_flush, div_valid}, 64'd2);
    @(posedge clk);
    #1;
    flush = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("wait_flush_one_cycle", 64'(div_flush), 64'd0);
    chk("wait_flush_idle", 64'(in_ready), 64'd1);
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (res_valid) seen = 1;
    end
    chk("wait_flush_no_result", 64'(seen), 64'd0);
    force_lat = -1;
    @(posedge clk);
    #1;

    send(2'd1, 0, 64'd40, 64'd4, 64'd10, waited);
    flush = 1'b1;
    @(negedge clk);
    chk("hs_flush_precond", {62'b0, div_valid, div_ready}, 64'd3);
    @(posedge clk);
    #1;
    flush = 1'b0;
    exp_q.delete();
    exp_issue = 0;
    @(negedge clk);
    chk("drain_flush", {62'b0, div_flush, div_valid}, 64'd2);
    chk("drain_not_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("drain_done", {62'b0, div_flush, in_ready}, 64'd1);
    @(posedge clk);
    #1;
    send(2'd1, 0, 64'd9, 64'd3, 64'd3, waited);
    wait_done(100);

    div_hold = 1;
    tick();
    send(2'd1, 0, 64'd50, 64'd5, 64'd10, waited);
    flush = 1'b1;
    @(negedge clk);
    chk("issue_stall_precond", {62'b0, div_valid, div_ready}, 64'd2);
    @(posedge clk);
    #1;
    flush = 1'b0;
    exp_q.delete();
    exp_issue = 0;
    div_hold = 0;
    @(negedge clk);
    chk("issue_drop", {61'b0, div_valid, div_flush, in_ready}, 64'd1);
    @(posedge clk);
    #1;

    rr_rand = 1;
    fl_rand = 1;
    stall_rand = 1;
    for (int i = 0; i < 300; i++) begin
      op = 2'($urandom_range(0, 3));
      w = 1'($urandom_range(0, 1));
      a = {$urandom(), $urandom()};
      b = {$urandom(), $urandom()};
      kind = $urandom_range(0, 9);
      case (kind)
        0: b = w ? {$urandom(), 32'h0} : 64'd0;
        1: begin
          a = w ? {$urandom(), 32'h8000_0000} : 64'h8000_0000_0000_0000;
          b = w ? {$urandom(), 32'hFFFF_FFFF} : '1;
        end
        2: begin
          a = 64'($urandom_range(0, 1000));
          b = 64'($urandom_range(1, 20));
          if ($urandom_range(0, 1) == 1) a = -a;
          if ($urandom_range(0, 1) == 1) b = -b;
        end
        3: b = 64'($urandom_range(1, 9));
        default: ;
      endcase
      send(op, w, a, b, ref_result(op, w, a, b), waited);
      wait_done(300);
    end
    rr_rand = 0;
    fl_rand = 0;
    res_ready = 1'b1;
    repeat (5) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_issue_ctrl.md
Name: div_issue_ctrl

Overview:
- Initiator side of the iterative divider handshake, sitting between the EXU's M-extension decode and the multi-cycle divider.
- Accepts one RV64M divide/remainder op at a time from EXU (valid/ready) and resolves divide-by-zero and signed overflow locally.
- Otherwise issues the op to the divider, holds its controls stable, captures the single-cycle result pulse, sign-extends W results and presents them to writeback (valid/ready).
- Handles pipeline flush, including cancelling an in-flight divide.

Parameters:
XLEN, 64, datapath width; only 64 is supported.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush  in  1  cancel current op; in-flight result discarded
in_valid  in  1  EXU op valid
in_ready  out  1  controller can accept op
in_op  in  2  0=DIV 1=DIVU 2=REM 3=REMU
in_word  in  1  W variant (32-bit op, 64-bit sign-extended result)
in_src1  in  64  dividend
in_src2  in  64  divisor
res_valid  out  1  result valid to writeback
res_ready  in  1  writeback accepts result
res_data  out  64  result
div_valid  out  1  request to divider
div_ready  in  1  divider idle/accepting
div_flush  out  1  cancel divider
div_divw  out  1  32-bit divide
div_signed  out  1  signed divide
div_dividend  out  64  dividend to divider
div_divisor  out  64  divisor to divider
div_out_valid  in  1  divider result pulse (one cycle)
div_quotient  in  64  quotient (W: zero-extended low 32)
div_remainder  in  64  remainder (W: zero-extended low 32)

Behaviour:
- Reset (sync, rst high): state IDLE; in_ready=1 only when rst low; res_valid=0, res_data=0, div_valid=0, div_flush=0, div_divw=0, div_signed=0, div_dividend=0, div_divisor=0. The divider shares rst.
- States: IDLE, ISSUE, WAIT, DRAIN, DONE.
- in_ready = (state==IDLE) && !flush. Acceptance: in_valid && in_ready. On acceptance, register op, word, src1, src2; signed = op is DIV or REM.
- Special-case check at acceptance. W ops use src[31:0] with 32-bit sign rules.
  - Divisor zero: quotient = all ones (W: 0xFFFFFFFF sign-extended = all ones); remainder = dividend (W: sext(src1[31:0])).
  - Signed overflow (dividend = most-negative, divisor = -1): quotient = dividend (W: 0xFFFFFFFF80000000); remainder = 0.
  - Special case: load res_data, go DONE. Latency is 1 cycle from acceptance to res_valid; the divider is not touched.
- Otherwise go ISSUE.
- ISSUE: div_valid=1.
  - div_ready high: handshake completes. Go WAIT; div_valid drops next cycle.
  - div_ready low: stay in ISSUE.
- Control hold: div_divw, div_signed, div_dividend and div_divisor are registered and held constant from ISSUE entry until the result is captured. The divider samples divw/signed at its output.
- WAIT: on div_out_valid, capture the result:
  - op DIV/DIVU selects quotient; REM/REMU selects remainder.
  - word=1: res_data = sext(sel[31:0]); else res_data = sel.
  - Go DONE.
- DONE: res_valid=1; res_data stable while res_ready low. On res_ready, go IDLE; a new op can be accepted the following cycle (no same-cycle bypass).
- Flush rules (flush has priority over all other events in the same cycle):
  - IDLE: no acceptance.
  - ISSUE with div_ready high that cycle: handshake happened. Go DRAIN; DRAIN pulses div_flush=1 for one cycle, then IDLE.
  - ISSUE with div_ready low: drop div_valid, go IDLE.
  - WAIT: div_flush=1 in the same cycle, go IDLE. A coincident div_out_valid is discarded.
  - DONE: res_valid deasserts next cycle, go IDLE.
- div_flush is asserted only in WAIT+flush or DRAIN; it is never high while div_valid is high.
- Unexpected div_out_valid outside WAIT is ignored.

Test Plan:
- DIVU 100/7, word=0 -> after the divider completes, res_valid with res_data=14; div_signed=0, div_divw=0 held through WAIT.
- REM src1=-7 (0xFFFF...FFF9), src2=2 -> res_data=0xFFFFFFFFFFFFFFFF; DIVW src1=0x0000_0000_FFFF_FFF0, src2=2 -> 0xFFFFFFFFFFFFFFF8.
- DIV x/0 with src1=123 -> res_data=all ones, 1-cycle latency, div_valid never asserted; REMUW src1=0x1_8000_0005, src2=0 -> 0xFFFFFFFF80000005.
- DIVW src1=0x80000000, src2=0xFFFFFFFF -> res_data=0xFFFFFFFF80000000, divider bypassed; REM 0x8000000000000000 % -1 -> 0.
- res_ready held low 10 cycles in DONE -> res_valid and res_data stable, in_ready=0; release -> IDLE, next op accepted the cycle after.
- flush at WAIT cycle 5 -> one-cycle div_flush, no res_valid; flush on the ISSUE handshake cycle -> div_flush in DRAIN next cycle; a subsequent DIVU 9/3 returns 3.
